wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the single register-file write port between the in-order writeback stage and a
//   long-latency unit (mul/div, uncached load) that returns results out of band.
//   Buffers LU results in a small pending FIFO. Keeps a busy scoreboard of LU destinations
//   and raises stalls to decode (RAW/WAW) and to writeback (port full).
//   Sits between writeback and the register file; its rf_* outputs drive the RF write port directly.
// PARAMETERS
//   W      `WORD_WIDTH   data width
//   AW     `REG_ADDR_W   register address width (32 regs at default 5)
//   DEPTH  2             pending-FIFO entries; power of two, >=2
// PORTS
//   clk           in   1      clock
//   rst           in   1      reset, synchronous, active-low (rst==0 resets)
//   pipe_we       in   1      writeback stage wants to write this cycle
//   pipe_addr     in   AW     writeback destination
//   pipe_data     in   W      writeback data
//   lu_valid      in   1      LU result valid
//   lu_addr       in   AW     LU result destination
//   lu_data       in   W      LU result data
//   lu_ready      out  1      arbiter can take LU result (combinational: rst & ~full)
//   lu_issue      in   1      decode issues an LU op this cycle
//   lu_issue_addr in   AW     destination of the issued LU op
//   id_rs, id_rt  in   AW     decode source operands
//   id_rd         in   AW     decode destination (WAW check)
//   hazard_stall  out  1      comb: busy[id_rs]|busy[id_rt]|busy[id_rd]; r0 never busy
//   pipe_stall    out  1      comb: pipe_we & full; writeback must hold its values
//   rf_we         out  1      registered RF write enable
//   rf_addr       out  AW     registered RF write address
//   rf_data       out  W      registered RF write data
//   pend_cnt      out  clog2(DEPTH)+1  FIFO occupancy (debug/perf)
// BEHAVIOUR
//   Reset (rst==0 at posedge): rf_we=0, rf_addr=0, rf_data=0, FIFO emptied, pend_cnt=0, busy=0.
//     lu_ready=0 and pipe_stall=0 while rst==0. Mid-operation reset discards buffered LU results.
//   Grant, evaluated each cycle in priority order:
//     1 FIFO full      -> FIFO head; pipe_stall=pipe_we
//     2 pipe_we        -> pipeline
//     3 FIFO non-empty -> FIFO head
//     4 lu_valid       -> LU bypass (the result is written directly, never enqueued)
//     5 none           -> rf_we<=0
//   Granted source is registered into rf_* at the next posedge (latency 1).
//     LU bypass: 1 cycle from lu_valid to rf_we.
//   Enqueue: lu_valid & lu_ready & grant!=LU-bypass. Dequeue: grant==FIFO.
//     Enqueue and dequeue in one cycle are legal; occupancy is then unchanged.
//     Pointers wrap modulo DEPTH. FIFO order = LU return order.
//   r0: a granted write with addr==0 still consumes the grant, but rf_we<=0.
//     lu_issue_addr==0 does not set busy.
//   Scoreboard busy[2^AW]:
//     - lu_issue sets busy[lu_issue_addr] at the posedge.
//     - A granted LU write (bypass or FIFO) clears busy[addr] at the same posedge as rf_we rises.
//     - Set and clear of the same addr in one cycle: the set wins.
//     - Decode must not issue while hazard_stall=1, so at most one LU op is in flight per register.
//   pipe_stall never depends on lu_valid. lu_ready depends only on occupancy, so there are no comb loops.
//   Starvation: the FIFO is drained whenever pipe_we=0 or it fills. The pipeline is stalled at most
//     one cycle per full event.
// STRUCTURE
//   defines.v gains:
//     - `WBARB_GNT_W and grant codes `WBARB_GNT_NONE/PIPE/FIFO/LU
//     - `WBARB_DEPTH default
//   One sub-module, wb_pend_fifo: sync FIFO {addr,data}, DEPTH, push/pop/full/empty/count,
//     same clk/rst convention.
//   The arbiter holds the grant mux, output registers and the scoreboard.
// TESTING
//   1 Reset: hold rst=0 for 3 cycles with pipe_we=1, lu_valid=1 -> rf_we=0, lu_ready=0,
//     pipe_stall=0, pend_cnt=0.
//   2 Bypass: idle, lu_valid=1 addr=5 data=0xDEAD -> next cycle rf_we=1 rf_addr=5
//     rf_data=0xDEAD; busy[5] cleared.
//   3 Contention: pipe_we=1 (r3,0x11) and lu_valid=1 (r7,0x22) for 1 cycle -> r3/0x11, then r7/0x22
//     one cycle later; pend_cnt 1 then 0.
//   4 Full: pipe_we=1 continuously, LU returns r8,r9 back-to-back ->
//     - pend_cnt=2, lu_ready=0, pipe_stall=1 for exactly one cycle
//     - rf writes r8 (FIFO) then pipeline resumes
//     - r9 drains when pipe_we drops
//   5 Scoreboard: lu_issue r4 -> hazard_stall=1 for id_rs=4, id_rt=4 or id_rd=4 until the LU write of
//     r4 is granted. id_rs=0 never stalls. A same-cycle reissue of r4 keeps busy[4]=1.
//   6 Mid-reset: FIFO holding 2 entries, assert rst=0 for 1 cycle -> pend_cnt=0, busy=0,
//     no stale write after release.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, default FIFO depth and grant codes for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int WBARB_DEPTH = 2;
  localparam int WBARB_GNT_W = 2;

  typedef enum logic [WBARB_GNT_W-1:0] {
    WBARB_GNT_NONE = 2'd0,
    WBARB_GNT_PIPE = 2'd1,
    WBARB_GNT_FIFO = 2'd2,
    WBARB_GNT_LU   = 2'd3
  } wbarb_gnt_e;

  // Grants that retire a long-latency result and therefore clear its busy bit.
  function automatic logic is_lu_grant(input wbarb_gnt_e g);
    return (g == WBARB_GNT_FIFO) || (g == WBARB_GNT_LU);
  endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Synchronous FIFO of {addr,data} pairs holding long-latency results waiting for the RF write port.
module wb_pend_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int W     = WORD_WIDTH,
  parameter int AW    = REG_ADDR_W,
  parameter int DEPTH = WBARB_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [W-1:0]  data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage needs no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single RF write port between writeback and a long-latency unit, buffering
// LU results and tracking in-flight LU destinations for decode hazard stalls.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int W     = WORD_WIDTH,
  parameter int AW    = REG_ADDR_W,
  parameter int DEPTH = WBARB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_we,
  input  logic [AW-1:0]          pipe_addr,
  input  logic [W-1:0]           pipe_data,
  input  logic                   lu_valid,
  input  logic [AW-1:0]          lu_addr,
  input  logic [W-1:0]           lu_data,
  output logic                   lu_ready,
  input  logic                   lu_issue,
  input  logic [AW-1:0]          lu_issue_addr,
  input  logic [AW-1:0]          id_rs,
  input  logic [AW-1:0]          id_rt,
  input  logic [AW-1:0]          id_rd,
  output logic                   hazard_stall,
  output logic                   pipe_stall,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_addr,
  output logic [W-1:0]           rf_data,
  output logic [$clog2(DEPTH):0] pend_cnt
);

  localparam int NREG = 2 ** AW;

  // Handshake: an LU result transfers on a cycle where lu_valid && lu_ready, either
  // straight to the RF (bypass grant) or into the pending FIFO; otherwise the LU holds it.

  wbarb_gnt_e    gnt;
  logic [AW-1:0] gnt_addr;
  logic [W-1:0]  gnt_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW-1:0] head_addr;
  logic [W-1:0]  head_data;
  logic          enq;
  logic          deq;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  wb_pend_fifo #(.W(W), .AW(AW), .DEPTH(DEPTH)) u_pend_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_addr (lu_addr),
    .push_data (lu_data),
    .pop       (deq),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pend_cnt)
  );

  // A full FIFO preempts writeback for one cycle so buffered results cannot starve.
  always_comb begin
    gnt = WBARB_GNT_NONE;
    if (fifo_full)        gnt = WBARB_GNT_FIFO;
    else if (pipe_we)     gnt = WBARB_GNT_PIPE;
    else if (!fifo_empty) gnt = WBARB_GNT_FIFO;
    else if (lu_valid)    gnt = WBARB_GNT_LU;
  end

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    case (gnt)
      WBARB_GNT_PIPE: begin gnt_addr = pipe_addr; gnt_data = pipe_data; end
      WBARB_GNT_FIFO: begin gnt_addr = head_addr; gnt_data = head_data; end
      WBARB_GNT_LU:   begin gnt_addr = lu_addr;   gnt_data = lu_data;   end
      default:        begin gnt_addr = '0;        gnt_data = '0;        end
    endcase
  end

  assign lu_ready   = rst & ~fifo_full;
  assign pipe_stall = rst & pipe_we & fifo_full;
  assign enq        = lu_valid & lu_ready & (gnt != WBARB_GNT_LU);
  assign deq        = (gnt == WBARB_GNT_FIFO);

  // Issue is applied after retirement so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (is_lu_grant(gnt)) busy_nxt[gnt_addr] = 1'b0;
    if (lu_issue && (lu_issue_addr != '0)) busy_nxt[lu_issue_addr] = 1'b1;
  end

  assign hazard_stall = busy[id_rs] | busy[id_rt] | busy[id_rd];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      busy    <= '0;
    end else begin
      rf_we <= (gnt != WBARB_GNT_NONE) && (gnt_addr != '0);
      if (gnt != WBARB_GNT_NONE) begin
        rf_addr <= gnt_addr;
        rf_data <= gnt_data;
      end
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized plus directed bench for wb_port_arbiter with a queue-based reference model and scoreboard.
module tb_wb_port_arbiter;

  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int EW    = 2 + AW + W;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [W-1:0]  pipe_data;
  logic          lu_valid;
  logic [AW-1:0] lu_addr;
  logic [W-1:0]  lu_data;
  logic          lu_ready;
  logic          lu_issue;
  logic [AW-1:0] lu_issue_addr;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          hazard_stall;
  logic          pipe_stall;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [W-1:0]  rf_data;
  logic [1:0]    pend_cnt;

  int total = 0;
  int bad   = 0;

  // Expected RF port after each posedge: {check_all, we, addr, data}.
  logic [EW-1:0]     exp_q[$];
  logic [AW+W-1:0]   m_pend[$];
  bit                m_busy[32];
  bit                m_known = 1'b0;
  bit                lu_acc  = 1'b1;

  wb_port_arbiter #(.W(W), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_we       (pipe_we),
    .pipe_addr     (pipe_addr),
    .pipe_data     (pipe_data),
    .lu_valid      (lu_valid),
    .lu_addr       (lu_addr),
    .lu_data       (lu_data),
    .lu_ready      (lu_ready),
    .lu_issue      (lu_issue),
    .lu_issue_addr (lu_issue_addr),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .hazard_stall  (hazard_stall),
    .pipe_stall    (pipe_stall),
    .rf_we         (rf_we),
    .rf_addr       (rf_addr),
    .rf_data       (rf_data),
    .pend_cnt      (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks combinational outputs against the model, advances the model by one clock, then clocks the DUT.
  task automatic cycle();
    bit            full;
    bit            wv;
    bit            lu_w;
    bit            byp;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW+W-1:0] e;
    #1;
    full = (m_pend.size() == DEPTH);
    if (!rst) begin
      chk("lu_ready_rst", 32'(lu_ready), 32'd0);
      chk("pipe_stall_rst", 32'(pipe_stall), 32'd0);
    end else begin
      chk("lu_ready", 32'(lu_ready), 32'(!full));
      chk("pipe_stall", 32'(pipe_stall), 32'(pipe_we && full));
    end
    if (m_known) begin
      chk("pend_cnt", 32'(pend_cnt), 32'(m_pend.size()));
      chk("hazard_stall", 32'(hazard_stall), 32'(m_busy[id_rs] | m_busy[id_rt] | m_busy[id_rd]));
    end
    if (!rst) begin
      m_pend.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      lu_acc  = 1'b1;
      m_known = 1'b1;
      exp_q.push_back({1'b1, 1'b0, {AW{1'b0}}, {W{1'b0}}});
    end else begin
      wv = 1'b0; lu_w = 1'b0; byp = 1'b0; wa = '0; wd = '0;
      if (full) begin
        e = m_pend.pop_front(); wv = 1'b1; lu_w = 1'b1; wa = e[AW+W-1:W]; wd = e[W-1:0];
      end else if (pipe_we) begin
        wv = 1'b1; wa = pipe_addr; wd = pipe_data;
      end else if (m_pend.size() > 0) begin
        e = m_pend.pop_front(); wv = 1'b1; lu_w = 1'b1; wa = e[AW+W-1:W]; wd = e[W-1:0];
      end else if (lu_valid) begin
        wv = 1'b1; lu_w = 1'b1; byp = 1'b1; wa = lu_addr; wd = lu_data;
      end
      lu_acc = !full;
      if (lu_valid && !full && !byp) m_pend.push_back({lu_addr, lu_data});
      if (lu_w) m_busy[wa] = 1'b0;
      if (lu_issue && lu_issue_addr != 0) m_busy[lu_issue_addr] = 1'b1;
      exp_q.push_back({1'b0, wv && (wa != 0), wa, wd});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the registered write port against the oldest expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_we", 32'(rf_we), 32'(e[EW-2]));
      if (e[EW-1] || e[EW-2]) begin
        chk("rf_addr", 32'(rf_addr), 32'(e[AW+W-1:W]));
        chk("rf_data", rf_data, e[W-1:0]);
      end
    end
  end

  task automatic idle();
    rst = 1'b1; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    lu_issue = 1'b0; lu_issue_addr = '0; id_rs = '0; id_rt = '0; id_rd = '0;
  endtask

  task automatic set_pipe(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    pipe_we = we; pipe_addr = a; pipe_data = d;
  endtask

  task automatic set_lu(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
    lu_valid = v; lu_addr = a; lu_data = d;
  endtask

  initial begin
    idle();
    // Reset held with activity on both sources.
    rst = 1'b0; set_pipe(1'b1, 5'd3, 32'h1); set_lu(1'b1, 5'd4, 32'h2);
    repeat (3) cycle();
    idle(); cycle();

    // Bypass of an issued r5.
    lu_issue = 1'b1; lu_issue_addr = 5'd5; cycle();
    idle(); id_rs = 5'd5; cycle();
    set_lu(1'b1, 5'd5, 32'hDEAD); id_rs = 5'd5; cycle();
    idle(); id_rs = 5'd5; cycle();

    // Contention: pipeline first, LU result one cycle later through the FIFO.
    set_pipe(1'b1, 5'd3, 32'h11); set_lu(1'b1, 5'd7, 32'h22); cycle();
    idle(); cycle(); cycle();

    // Full: continuous writeback while r8, r9 return back-to-back.
    set_pipe(1'b1, 5'd1, 32'h100); set_lu(1'b1, 5'd8, 32'h88); cycle();
    set_pipe(1'b1, 5'd2, 32'h200); set_lu(1'b1, 5'd9, 32'h99); cycle();
    set_lu(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin set_pipe(1'b1, 5'(10 + i), 32'h300 + i); cycle(); end
    idle(); cycle(); cycle();

    // Scoreboard on r4, including a same-cycle retire and reissue.
    lu_issue = 1'b1; lu_issue_addr = 5'd4; cycle();
    idle(); id_rs = 5'd4; cycle();
    id_rs = 5'd0; id_rt = 5'd4; cycle();
    id_rt = 5'd0; id_rd = 5'd4; cycle();
    id_rd = 5'd0; cycle();
    set_lu(1'b1, 5'd4, 32'h44); lu_issue = 1'b1; lu_issue_addr = 5'd4; cycle();
    idle(); id_rs = 5'd4; cycle();
    set_lu(1'b1, 5'd4, 32'h45); id_rs = 5'd4; cycle();
    idle(); id_rs = 5'd4; cycle();

    // Mid-operation reset with two buffered results.
    set_pipe(1'b1, 5'd20, 32'hA0); set_lu(1'b1, 5'd10, 32'hB0); cycle();
    set_pipe(1'b1, 5'd21, 32'hA1); set_lu(1'b1, 5'd11, 32'hB1); cycle();
    idle(); rst = 1'b0; cycle();
    idle(); repeat (3) cycle();

    // Randomized traffic; LU holds an unaccepted result.
    for (int n = 0; n < 800; n++) begin
      logic [AW-1:0] a;
      rst = ($urandom_range(0, 199) != 0);
      set_pipe($urandom_range(0, 99) < 45, AW'($urandom_range(0, 31)), $urandom);
      if (!(lu_valid && !lu_acc))
        set_lu($urandom_range(0, 99) < 40, AW'($urandom_range(0, 31)), $urandom);
      a = AW'($urandom_range(1, 31));
      lu_issue = ($urandom_range(0, 99) < 30) && !m_busy[a];
      lu_issue_addr = a;
      id_rs = AW'($urandom_range(0, 31));
      id_rt = AW'($urandom_range(0, 31));
      id_rd = lu_issue ? a : AW'($urandom_range(0, 31));
      cycle();
    end

    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("exp_q_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
